// File: rtl/victim_cache_control.sv
// Sequencer for the 8-way fully associative victim cache between L1 and L2.
// Optional hit/miss counters are enabled with the VICTIM_PERF_CNT_EN macro.
module victim_cache_control #(
  parameter int unsigned PERF_CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buf_mem_read,
  input  logic       buf_mem_write,
  input  logic       buf_evict_dirty,
  output logic       buf_mem_resp,
  output logic       s_mem_read,
  output logic       s_mem_write,
  input  logic       s_mem_resp,
  input  logic [7:0] hits,
  input  logic [7:0] way_valid,
  input  logic [7:0] way_dirty,
  input  logic [6:0] lru_out,
  output logic       load_d,
  output logic       load_lru,
  output logic [6:0] lru_in,
  output logic       valid,
  output logic       dirty,
  output logic [2:0] index_sel,
  output logic       read_src_sel,
  output logic       write_sel,
  output logic [3:0] smemaddr_sel
`ifdef VICTIM_PERF_CNT_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] hit_count,
  output logic [PERF_CNT_WIDTH-1:0] miss_count
`endif
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_FILL  = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_ALLOC = 3'd5;

  logic [2:0] state, state_next;
  logic [2:0] sweep_ctr;
  logic [2:0] victim, victim_next;

  logic       any_hit;
  logic [2:0] hit_way;
  logic       any_invalid;
  logic [2:0] invalid_way;
  logic [2:0] plru_way;

  // Tree bits point at the LRU side; a touch steers every bit on the path away from w.
  function automatic logic [6:0] plru_touch(input logic [6:0] cur, input logic [2:0] w);
    logic [6:0] nxt;
    nxt    = cur;
    nxt[0] = ~w[2];
    if (!w[2]) begin
      nxt[1] = ~w[1];
      if (!w[1]) nxt[3] = ~w[0];
      else       nxt[4] = ~w[0];
    end else begin
      nxt[2] = ~w[1];
      if (!w[1]) nxt[5] = ~w[0];
      else       nxt[6] = ~w[0];
    end
    return nxt;
  endfunction

  // Lowest index wins so a corrupted multi-hit vector still selects one way.
  always_comb begin
    any_hit     = 1'b0;
    hit_way     = '0;
    any_invalid = 1'b0;
    invalid_way = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (hits[i] && !any_hit) begin
        any_hit = 1'b1;
        hit_way = i[2:0];
      end
      if (!way_valid[i] && !any_invalid) begin
        any_invalid = 1'b1;
        invalid_way = i[2:0];
      end
    end
  end

  always_comb begin
    plru_way = '0;
    if (!lru_out[0]) begin
      if (!lru_out[1]) plru_way = {2'b00, lru_out[3]};
      else             plru_way = {2'b01, lru_out[4]};
    end else begin
      if (!lru_out[2]) plru_way = {2'b10, lru_out[5]};
      else             plru_way = {2'b11, lru_out[6]};
    end
  end

  always_comb begin
    state_next  = state;
    victim_next = victim;
    case (state)
      ST_INIT: begin
        if (sweep_ctr == 3'd7) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (buf_mem_write) begin
          if (!any_hit) begin
            victim_next = any_invalid ? invalid_way : plru_way;
            if (way_valid[victim_next] && way_dirty[victim_next]) state_next = ST_WB;
            else                                                  state_next = ST_ALLOC;
          end
        end else if (buf_mem_read && !any_hit) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: if (s_mem_resp) state_next = ST_FILL;
      ST_FILL:  state_next = ST_IDLE;
      ST_WB:    if (s_mem_resp) state_next = ST_ALLOC;
      ST_ALLOC: state_next = ST_IDLE;
      default:  state_next = ST_INIT;
    endcase
  end

  // Outputs are forced low while reset is high so an aborted L2 access drops at once.
  always_comb begin
    buf_mem_resp = 1'b0;
    s_mem_read   = 1'b0;
    s_mem_write  = 1'b0;
    load_d       = 1'b0;
    load_lru     = 1'b0;
    lru_in       = '0;
    valid        = 1'b0;
    dirty        = 1'b0;
    index_sel    = '0;
    read_src_sel = 1'b0;
    write_sel    = 1'b0;
    smemaddr_sel = '0;
    if (!reset) begin
      case (state)
        ST_INIT: begin
          load_d    = 1'b1;
          write_sel = 1'b1;
          index_sel = sweep_ctr;
          if (sweep_ctr == 3'd7) load_lru = 1'b1;
        end
        ST_IDLE: begin
          if (buf_mem_write) begin
            if (any_hit) begin
              load_d       = 1'b1;
              write_sel    = 1'b1;
              index_sel    = hit_way;
              valid        = 1'b1;
              dirty        = buf_evict_dirty | way_dirty[hit_way];
              load_lru     = 1'b1;
              lru_in       = plru_touch(lru_out, hit_way);
              buf_mem_resp = 1'b1;
            end
          end else if (buf_mem_read && any_hit) begin
            read_src_sel = 1'b0;
            index_sel    = hit_way;
            load_lru     = 1'b1;
            lru_in       = plru_touch(lru_out, hit_way);
            buf_mem_resp = 1'b1;
          end
        end
        ST_FETCH: begin
          s_mem_read   = 1'b1;
          smemaddr_sel = 4'd8;
        end
        ST_FILL: begin
          read_src_sel = 1'b1;
          buf_mem_resp = 1'b1;
        end
        ST_WB: begin
          s_mem_write  = 1'b1;
          index_sel    = victim;
          smemaddr_sel = {1'b0, victim};
        end
        ST_ALLOC: begin
          load_d       = 1'b1;
          write_sel    = 1'b1;
          index_sel    = victim;
          valid        = 1'b1;
          dirty        = buf_evict_dirty;
          load_lru     = 1'b1;
          lru_in       = plru_touch(lru_out, victim);
          buf_mem_resp = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      sweep_ctr <= '0;
      victim    <= '0;
    end else begin
      state  <= state_next;
      victim <= victim_next;
      if (state == ST_INIT) sweep_ctr <= sweep_ctr + 3'd1;
    end
  end

`ifdef VICTIM_PERF_CNT_EN
  logic read_hit_ack;
  logic read_miss_ack;

  assign read_hit_ack  = (state == ST_IDLE) && !buf_mem_write && buf_mem_read && any_hit;
  assign read_miss_ack = (state == ST_FILL);

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (read_hit_ack && (hit_count != '1))   hit_count  <= hit_count + 1'b1;
      if (read_miss_ack && (miss_count != '1)) miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_victim_cache_control.sv
// Scoreboard bench for victim_cache_control: behavioural victim-cache model vs DUT.
// Models the entry array and L2 around the sequencer; VICTIM_PERF_CNT_EN adds counter checks.
module tb_victim_cache_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       buf_mem_read, buf_mem_write, buf_evict_dirty, buf_mem_resp;
  logic       s_mem_read, s_mem_write, s_mem_resp;
  logic [7:0] hits, way_valid, way_dirty;
  logic [6:0] lru_out, lru_in;
  logic       load_d, load_lru, valid, dirty, read_src_sel, write_sel;
  logic [2:0] index_sel;
  logic [3:0] smemaddr_sel;
`ifdef VICTIM_PERF_CNT_EN
  logic [15:0] hit_count, miss_count;
  int ref_hit_cnt, ref_miss_cnt;
`endif

  always #5 clk = ~clk;

  victim_cache_control #(.PERF_CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .buf_mem_read(buf_mem_read), .buf_mem_write(buf_mem_write),
    .buf_evict_dirty(buf_evict_dirty), .buf_mem_resp(buf_mem_resp),
    .s_mem_read(s_mem_read), .s_mem_write(s_mem_write), .s_mem_resp(s_mem_resp),
    .hits(hits), .way_valid(way_valid), .way_dirty(way_dirty), .lru_out(lru_out),
    .load_d(load_d), .load_lru(load_lru), .lru_in(lru_in),
    .valid(valid), .dirty(dirty), .index_sel(index_sel),
    .read_src_sel(read_src_sel), .write_sel(write_sel), .smemaddr_sel(smemaddr_sel)
`ifdef VICTIM_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Entry array and PLRU register as the datapath would hold them.
  logic [7:0]  dp_valid, dp_dirty;
  logic [15:0] dp_addr [8];
  logic [6:0]  dp_lru;
  logic [15:0] cur_addr;
  logic        force_hi;

  assign way_valid = dp_valid;
  assign way_dirty = dp_dirty;
  assign lru_out   = dp_lru;

  always_comb begin
    hits = '0;
    for (int i = 0; i < 8; i++)
      if (dp_valid[i] && dp_addr[i] == cur_addr) hits[i] = 1'b1;
    if (force_hi) hits[7] = 1'b1;
  end

  // Reference victim cache: contents plus the seven PLRU tree nodes.
  bit          ref_v [8];
  bit          ref_d [8];
  logic [15:0] ref_a [8];
  bit          ref_t [7];

  typedef struct {
    int          kind;   // 0 L2 read, 1 L2 write, 2 write resp, 3 read hit, 4 read miss
    int          way;
    logic [15:0] addr;
    bit          d;
    logic [6:0]  lru;
  } ev_t;
  ev_t exp_q[$];

  int  l2_fixed = -1;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [6:0] ref_tvec();
    logic [6:0] v;
    for (int i = 0; i < 7; i++) v[i] = ref_t[i];
    return v;
  endfunction

  // Node k covers a range of ways; its bit is 1 when the lower half was used most recently.
  function automatic void ref_touch(input int w);
    ref_t[0]         = (w < 4);
    ref_t[1 + w / 4] = ((w % 4) < 2);
    ref_t[3 + w / 2] = ((w % 2) == 0);
  endfunction

  function automatic int ref_victim();
    int h, q, r;
    for (int i = 0; i < 8; i++) if (!ref_v[i]) return i;
    h = ref_t[0] ? 4 : 0;
    q = ref_t[1 + h / 4] ? 2 : 0;
    r = ref_t[3 + (h + q) / 2] ? 1 : 0;
    return h + q + r;
  endfunction

  function automatic int ref_lookup(input logic [15:0] a);
    for (int i = 0; i < 8; i++) if (ref_v[i] && ref_a[i] == a) return i;
    return -1;
  endfunction

  function automatic void ref_clear();
    for (int i = 0; i < 8; i++) begin ref_v[i] = 0; ref_d[i] = 0; ref_a[i] = '0; end
    for (int i = 0; i < 7; i++) ref_t[i] = 0;
  endfunction

  function automatic logic [20:0] pk(input bit ld, input bit ll, input bit v, input bit d,
                                     input bit ws, input bit src, input logic [2:0] idx,
                                     input logic [6:0] lru, input bit sr, input bit sw,
                                     input logic [3:0] sa);
    return {ld, ll, v, d, ws, src, idx, lru, sr, sw, sa};
  endfunction

  // Datapath writes land on the clock edge the DUT commands them.
  initial begin
    logic c_ld, c_v, c_d, c_ll;
    logic [2:0] c_idx;
    logic [15:0] c_a;
    logic [6:0] c_lru;
    forever begin
      @(negedge clk);
      c_ld = load_d; c_idx = index_sel; c_v = valid; c_d = dirty;
      c_a = cur_addr; c_ll = load_lru; c_lru = lru_in;
      @(posedge clk); #1;
      if (c_ld) begin dp_valid[c_idx] = c_v; dp_dirty[c_idx] = c_d; dp_addr[c_idx] = c_a; end
      if (c_ll) dp_lru = c_lru;
    end
  end

  // L2 responder: one resp pulse after a per-request latency.
  initial begin
    bit busy = 0;
    int wait_c = 0;
    s_mem_resp = 1'b0;
    forever begin
      @(posedge clk); #1;
      s_mem_resp = 1'b0;
      if (reset || !(s_mem_read || s_mem_write)) busy = 0;
      else begin
        if (!busy) begin
          busy = 1;
          wait_c = (l2_fixed >= 0) ? l2_fixed : int'($urandom_range(0, 5));
        end
        if (wait_c == 0) begin s_mem_resp = 1'b1; busy = 0; end
        else wait_c--;
      end
    end
  end

  task automatic mon_event(input bit is_l2);
    ev_t e;
    logic [20:0] act, m, x;
    if (exp_q.size() == 0) begin
      check(is_l2 ? "unexpected_l2_req" : "unexpected_resp", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("event_order", 32'(is_l2), 32'(e.kind < 2));
    if (is_l2 != (e.kind < 2)) return;
    act = pk(load_d, load_lru, valid, dirty, write_sel, read_src_sel, index_sel, lru_in,
             s_mem_read, s_mem_write, smemaddr_sel);
    case (e.kind)
      0: begin m = pk(1,0,0,0,0,0,'0,'0,1,1,'1); x = pk(0,0,0,0,0,0,'0,'0,1,0,4'd8); end
      1: begin
        m = pk(1,0,0,0,0,0,'1,'0,1,1,'1);
        x = pk(0,0,0,0,0,0,3'(e.way),'0,0,1,{1'b0,3'(e.way)});
        check("wb_addr", 32'(dp_addr[smemaddr_sel[2:0]]), 32'(e.addr));
      end
      2: begin m = pk(1,1,1,1,1,0,'1,'1,1,1,'0); x = pk(1,1,1,e.d,1,0,3'(e.way),e.lru,0,0,'0); end
      3: begin m = pk(1,1,0,0,0,1,'1,'1,1,1,'0); x = pk(0,1,0,0,0,0,3'(e.way),e.lru,0,0,'0); end
      default: begin m = pk(1,0,0,0,0,1,'0,'0,1,1,'0); x = pk(0,0,0,0,0,1,'0,'0,0,0,'0); end
    endcase
    check($sformatf("event_kind%0d", e.kind), 32'(act & m), 32'(x & m));
  endtask

  initial begin
    bit l2_prev = 0;
    forever begin
      @(negedge clk);
      if (!reset && mon_en) begin
        if ((s_mem_read || s_mem_write) && !l2_prev) mon_event(1'b1);
        if (buf_mem_resp) mon_event(1'b0);
        l2_prev = s_mem_read || s_mem_write;
      end else l2_prev = 0;
    end
  end

  task automatic reset_init();
    mon_en = 0;
    buf_mem_write = 0; buf_evict_dirty = 0;
    buf_mem_read = 1; cur_addr = 16'hBEE0;   // held request must be ignored during the sweep
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          32'({pk(load_d, load_lru, valid, dirty, write_sel, read_src_sel, index_sel, lru_in,
                  s_mem_read, s_mem_write, smemaddr_sel), buf_mem_resp}), 32'd0);
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("init_cycle%0d", i),
            32'({load_d, valid, dirty, index_sel, load_lru, (i == 7) ? lru_in : 7'd0,
                 buf_mem_resp, s_mem_read, s_mem_write}),
            32'({1'b1, 1'b0, 1'b0, 3'(i), (i == 7), 7'd0, 1'b0, 1'b0, 1'b0}));
    end
    buf_mem_read = 0;
    ref_clear();
`ifdef VICTIM_PERF_CNT_EN
    ref_hit_cnt = 0; ref_miss_cnt = 0;
`endif
    @(posedge clk); #1 mon_en = 1;
  endtask

  task automatic do_txn(input bit wr, input logic [15:0] a, input bit d, input bit fh);
    int w, v;
    bit got = 0;
    ev_t e;
    e = '{kind: 0, way: 0, addr: '0, d: 0, lru: '0};
    w = ref_lookup(a);
    if (wr) begin
      if (w < 0) begin
        v = ref_victim();
        if (ref_v[v] && ref_d[v]) begin
          e.kind = 1; e.way = v; e.addr = ref_a[v];
          exp_q.push_back(e);
        end
        w = v;
        ref_d[w] = d;
      end else ref_d[w] = ref_d[w] | d;
      ref_v[w] = 1; ref_a[w] = a;
      ref_touch(w);
      e.kind = 2; e.way = w; e.d = ref_d[w]; e.lru = ref_tvec();
      exp_q.push_back(e);
    end else if (w >= 0) begin
      ref_touch(w);
      e.kind = 3; e.way = w; e.lru = ref_tvec();
      exp_q.push_back(e);
`ifdef VICTIM_PERF_CNT_EN
      ref_hit_cnt++;
`endif
    end else begin
      e.kind = 0; exp_q.push_back(e);
      e.kind = 4; exp_q.push_back(e);
`ifdef VICTIM_PERF_CNT_EN
      ref_miss_cnt++;
`endif
    end
    cur_addr = a; buf_evict_dirty = wr ? d : 1'b0; force_hi = fh;
    buf_mem_write = wr; buf_mem_read = !wr;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (buf_mem_resp) got = 1;
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    buf_mem_read = 0; buf_mem_write = 0; force_hi = 0;
  endtask

  task automatic compare_state(input string tag);
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_way%0d", tag, i),
            32'({dp_valid[i], dp_valid[i] & dp_dirty[i], dp_valid[i] ? dp_addr[i] : 16'd0}),
            32'({ref_v[i], ref_v[i] & ref_d[i], ref_v[i] ? ref_a[i] : 16'd0}));
    check({tag, "_plru"}, 32'(dp_lru), 32'(ref_tvec()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit wr, d, fh;
    int w;
    logic [15:0] a;
    bit seen;
    ev_t e;
    force_hi = 0; cur_addr = '0;
    buf_mem_read = 0; buf_mem_write = 0; buf_evict_dirty = 0;
    dp_valid = '1; dp_dirty = '1; dp_lru = 7'h55;
    for (int i = 0; i < 8; i++) dp_addr[i] = 16'h1230;
    reset_init();

    do_txn(1, 16'h1230, 0, 0);
    compare_state("first_alloc");
    do_txn(0, 16'h1230, 0, 0);
    do_txn(0, 16'h4560, 0, 0);
    do_txn(1, 16'h1230, 1, 0);
    do_txn(1, 16'h1230, 0, 0);
    compare_state("sticky_dirty");

    for (int n = 0; n < 300; n++) begin
      wr = $urandom_range(0, 1);
      d  = $urandom_range(0, 1);
      a  = 16'h1000 + 16'($urandom_range(0, 13)) * 16'h10;
      w  = ref_lookup(a);
      fh = !wr && w >= 0 && w < 7 && $urandom_range(0, 3) == 0;
      do_txn(wr, a, d, fh);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    compare_state("random");
`ifdef VICTIM_PERF_CNT_EN
    check("hit_count", 32'(hit_count), 32'(ref_hit_cnt));
    check("miss_count", 32'(miss_count), 32'(ref_miss_cnt));
`endif

    reset_init();
    for (int i = 0; i < 8; i++) do_txn(1, 16'h2000 + 16'(i) * 16'h10, 1, 0);
    do_txn(1, 16'h2030, 0, 0);
    l2_fixed = 10;
    do_txn(1, 16'h2100, 1, 0);
    compare_state("ninth_write");

    // Start another dirty eviction and pull reset while the L2 write is outstanding.
    w = ref_victim();
    e = '{kind: 1, way: w, addr: ref_a[w], d: 0, lru: '0};
    exp_q.push_back(e);
    cur_addr = 16'h2200; buf_evict_dirty = 1; buf_mem_write = 1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (s_mem_write) seen = 1;
    end
    check("wb_started", 32'(seen), 32'd1);
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    check("reset_mid_wb", 32'({s_mem_write, s_mem_read, buf_mem_resp}), 32'd0);
    reset_init();
    check("queue_after_abort", 32'(exp_q.size()), 32'd0);

    l2_fixed = -1;
    do_txn(0, 16'h3330, 0, 0);
    do_txn(1, 16'h3330, 0, 0);
    do_txn(0, 16'h3330, 0, 0);
    compare_state("post_reset");
    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
